ysyx_22040125_pipe_ctrl: RTL and testbench
==========================================

# ysyx_22040125_pipe_ctrl

Central hazard and stall controller for the five-stage RV64 pipeline (IF, ID, EX, MEM, WB). It decides, every cycle, whether each inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC capture, hold or load a bubble. The decision covers load-use hazards, EX-stage redirects, multi-cycle divides and multi-cycle data-memory accesses. A bubble loads the pipeline register's reset/NOP value; a hold keeps the register's current contents. It also keeps a saturating stall-cycle counter for performance analysis.

## Interface
- CNT_W, 32, width of stall_cnt
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID
- id_rs1_en, id_rs2_en  in  1 each  source actually read
- ex_valid  in  1  EX holds a real instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  5  EX destination register
- ex_redirect  in  1  EX resolved a taken branch/jump or trap (wrong-path in IF/ID)
- ex_div_start  in  1  EX holds a div/rem requesting the divider
- div_done  in  1  divider result valid this cycle
- mem_req  in  1  MEM stage has a valid load/store access outstanding
- mem_ack  in  1  data memory completes access this cycle
- hold_pc, hold_ifid, hold_idex, hold_exmem  out  1 each  keep contents
- bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb  out  1 each  load NOP
- div_go  out  1  divider start accepted
- ctrl_state  out  2  RUN=0, MEM_WAIT=1, DIV_WAIT=2
- stall_cnt  out  CNT_W  cycles with any hold asserted

## Operation
- All outputs except ctrl_state and stall_cnt are combinational from the current state and inputs (zero-cycle).
- Default (RUN, no hazard): all hold_* = 0 and all bubble_* = 0.
- Priority in RUN: mem stall > divide start > redirect > load-use.
- Mem stall: condition is mem_req & ~mem_ack.
  - Assert hold_pc, hold_ifid, hold_idex and hold_exmem; assert bubble_memwb.
  - Next state MEM_WAIT.
  - If mem_req & mem_ack in the same cycle: no stall.
- MEM_WAIT:
  - While ~mem_ack: same outputs as a mem stall.
  - On mem_ack: all holds and bubbles 0 (MEM/WB captures the result); next state RUN.
- Divide: condition is ex_valid & ex_div_start with no mem stall.
  - div_go = 1 (one cycle).
  - Assert hold_pc, hold_ifid and hold_idex; assert bubble_exmem.
  - Next state DIV_WAIT. MEM/WB advances normally.
- DIV_WAIT:
  - While ~div_done: same outputs as the divide-start cycle, but div_go = 0.
  - On div_done: all outputs 0 (EX/MEM captures the quotient); next state RUN.
  - mem_req and ex_div_start are ignored in this state.
- Redirect: condition is ex_valid & ex_redirect with no higher-priority event.
  - Assert bubble_ifid and bubble_idex. No holds.
  - The PC loads the redirect target, which comes from the datapath.
- Load-use: condition is ex_valid & ex_is_load & ex_rd≠0 & ((id_rs1_en & id_rs1==ex_rd) | (id_rs2_en & id_rs2==ex_rd)).
  - Assert hold_pc and hold_ifid; assert bubble_idex.
  - Lasts one cycle: the load leaves EX, so the condition clears.
- A redirect that coincides with a mem stall is deferred. ID/EX is held, so ex_redirect stays asserted and is acted on in the first free RUN cycle. The same applies to a deferred divide start.
- stall_cnt:
  - Increments by 1 every cycle in which any hold_* = 1.
  - Saturates at all-ones and never wraps.
- Reset (rst = 0):
  - State RUN, stall_cnt = 0, div_go = 0.
  - All hold_* = 0, all bubble_* = 1 (the pipeline fills with NOPs).
- Reset overrides any state. A reset mid-divide or mid-access returns to RUN next cycle; the outstanding divide or memory access is abandoned.

## Timing
- Hazard response latency: 0 cycles, combinational in the detecting cycle.
- Each state transition takes effect at the next posedge clk.
- Load-use stall costs exactly 1 cycle.
- Redirect costs 2 bubbles.
- A divide of N cycles holds the front end for N+1 cycles: start cycle plus N wait cycles, with release in the div_done cycle.
- A memory access with ack after K wait cycles holds for K+1 cycles.
- stall_cnt updates one cycle after the hold it counts.

## Test plan
- Reset: rst low for 3 cycles → all bubble_* = 1, all hold_* = 0, ctrl_state = 0, stall_cnt = 0. After release with no inputs → all outputs 0.
- Load-use stall:
  - Stimulus: ex_is_load, ex_rd = 5, id_rs2 = 5, id_rs2_en = 1.
  - Response: hold_pc = hold_ifid = bubble_idex = 1 for one cycle; stall_cnt = 1.
  - Repeat with ex_rd = 0 → no stall.
- Redirect priority: ex_redirect = 1 together with a load-use match → bubble_ifid = bubble_idex = 1 and hold_ifid = 0.
- Memory wait:
  - Stimulus: mem_req = 1, mem_ack low for 3 cycles, then high.
  - Response: 4 cycles with hold_exmem = bubble_memwb = 1 (start cycle plus 3 MEM_WAIT cycles); release on the ack cycle; ctrl_state returns to 0; stall_cnt = 4.
  - Same-cycle ack → zero stall.
- Divide:
  - Stimulus: ex_div_start = 1, div_done after 8 cycles.
  - Response: div_go pulses once; hold_idex = bubble_exmem = 1 for 9 cycles; release in the div_done cycle.
  - Also: a divide start together with a mem stall → div_go = 0 until the mem stall clears.
- Saturation and reset mid-op:
  - Set CNT_W = 4 and hold continuously for 20 cycles → stall_cnt = 15.
  - Assert rst in DIV_WAIT → RUN and stall_cnt = 0 the next cycle.

Source files
------------

// File: rtl/ysyx_22040125_pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard/stall controller.
// The datapath side (master) reports hazard sources; the controller (slave) returns stage controls.
interface ysyx_22040125_pipe_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_en;
    logic       id_rs2_en;
    logic       ex_valid;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       ex_div_start;
    logic       div_done;
    logic       mem_req;
    logic       mem_ack;
    logic       hold_pc;
    logic       hold_ifid;
    logic       hold_idex;
    logic       hold_exmem;
    logic       bubble_ifid;
    logic       bubble_idex;
    logic       bubble_exmem;
    logic       bubble_memwb;
    logic       div_go;
    logic [1:0] ctrl_state;

    modport master (
        output id_rs1, id_rs2, id_rs1_en, id_rs2_en, ex_valid, ex_is_load, ex_rd,
               ex_redirect, ex_div_start, div_done, mem_req, mem_ack,
        input  hold_pc, hold_ifid, hold_idex, hold_exmem, bubble_ifid, bubble_idex,
               bubble_exmem, bubble_memwb, div_go, ctrl_state
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_en, id_rs2_en, ex_valid, ex_is_load, ex_rd,
               ex_redirect, ex_div_start, div_done, mem_req, mem_ack,
        output hold_pc, hold_ifid, hold_idex, hold_exmem, bubble_ifid, bubble_idex,
               bubble_exmem, bubble_memwb, div_go, ctrl_state
    );
endinterface

// File: rtl/ysyx_22040125_pipe_ctrl.sv
// Central hazard/stall controller for the five-stage pipeline: per-cycle hold/bubble decisions
// for each inter-stage register, plus a saturating count of stalled cycles.
module ysyx_22040125_pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22040125_pipe_ctrl_if.slave  pc,
    output logic [CNT_W-1:0]          stall_cnt
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StDivWait = 2'd2
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic mem_stall;
    logic div_start;
    logic redirect;
    logic load_use;
    logic any_hold;

    assign mem_stall = pc.mem_req & ~pc.mem_ack;
    assign div_start = pc.ex_valid & pc.ex_div_start;
    assign redirect  = pc.ex_valid & pc.ex_redirect;
    assign load_use  = pc.ex_valid & pc.ex_is_load & (pc.ex_rd != 5'd0) &
                       ((pc.id_rs1_en & (pc.id_rs1 == pc.ex_rd)) |
                        (pc.id_rs2_en & (pc.id_rs2 == pc.ex_rd)));

    always_comb begin
        pc.hold_pc      = 1'b0;
        pc.hold_ifid    = 1'b0;
        pc.hold_idex    = 1'b0;
        pc.hold_exmem   = 1'b0;
        pc.bubble_ifid  = 1'b0;
        pc.bubble_idex  = 1'b0;
        pc.bubble_exmem = 1'b0;
        pc.bubble_memwb = 1'b0;
        pc.div_go       = 1'b0;
        if (!rst) begin
            // Flush every stage with NOPs while reset is held.
            pc.bubble_ifid  = 1'b1;
            pc.bubble_idex  = 1'b1;
            pc.bubble_exmem = 1'b1;
            pc.bubble_memwb = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mem_stall) begin
                        {pc.hold_pc, pc.hold_ifid, pc.hold_idex, pc.hold_exmem} = 4'b1111;
                        pc.bubble_memwb = 1'b1;
                    end else if (div_start) begin
                        {pc.hold_pc, pc.hold_ifid, pc.hold_idex} = 3'b111;
                        pc.bubble_exmem = 1'b1;
                        pc.div_go       = 1'b1;
                    end else if (redirect) begin
                        pc.bubble_ifid = 1'b1;
                        pc.bubble_idex = 1'b1;
                    end else if (load_use) begin
                        pc.hold_pc     = 1'b1;
                        pc.hold_ifid   = 1'b1;
                        pc.bubble_idex = 1'b1;
                    end
                end
                StMemWait: begin
                    if (!pc.mem_ack) begin
                        {pc.hold_pc, pc.hold_ifid, pc.hold_idex, pc.hold_exmem} = 4'b1111;
                        pc.bubble_memwb = 1'b1;
                    end
                end
                StDivWait: begin
                    if (!pc.div_done) begin
                        {pc.hold_pc, pc.hold_ifid, pc.hold_idex} = 3'b111;
                        pc.bubble_exmem = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign any_hold = pc.hold_pc | pc.hold_ifid | pc.hold_idex | pc.hold_exmem;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mem_stall)      state_q <= StMemWait;
                    else if (div_start) state_q <= StDivWait;
                end
                StMemWait: if (pc.mem_ack)  state_q <= StRun;
                StDivWait: if (pc.div_done) state_q <= StRun;
                default:                    state_q <= StRun;
            endcase
            if (any_hold && (cnt_q != {CNT_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign pc.ctrl_state = state_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_ysyx_22040125_pipe_ctrl.sv
// Scoreboard bench for the pipeline hazard controller: directed scenarios plus random traffic,
// checked against a rule-level reference model.
module tb_ysyx_22040125_pipe_ctrl;
    localparam int unsigned CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Reason codes for the model's per-cycle decision.
    localparam int RNone = 0, RReset = 1, RMem = 2, RDivStart = 3, RDivWait = 4,
                   RRedir = 5, RLoadUse = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [CNT_W-1:0] stall_cnt;

    ysyx_22040125_pipe_ctrl_if bus ();

    ysyx_22040125_pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pc       (bus),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_en;
        logic       rs2_en;
        logic       ex_valid;
        logic       is_load;
        logic [4:0] rd;
        logic       redirect;
        logic       div_start;
        logic       div_done;
        logic       mem_req;
        logic       mem_ack;
    } stim_t;

    // ctl = {hold_pc, hold_ifid, hold_idex, hold_exmem,
    //        bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb, div_go}
    typedef struct packed {
        logic [8:0]       ctl;
        logic [1:0]       st;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    bit   m_mem = 1'b0;
    bit   m_div = 1'b0;
    int   m_cnt = 0;

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    function automatic logic [8:0] ctl_for(input int r);
        case (r)
            RReset:    return 9'b0000_1111_0;
            RMem:      return 9'b1111_0001_0;
            RDivStart: return 9'b1110_0010_1;
            RDivWait:  return 9'b1110_0010_0;
            RRedir:    return 9'b0000_1100_0;
            RLoadUse:  return 9'b1100_0100_0;
            default:   return 9'b0000_0000_0;
        endcase
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        int   r;
        bit   lu;
        @(posedge clk);
        #1;
        rst              = s.rst;
        bus.id_rs1       = s.rs1;
        bus.id_rs2       = s.rs2;
        bus.id_rs1_en    = s.rs1_en;
        bus.id_rs2_en    = s.rs2_en;
        bus.ex_valid     = s.ex_valid;
        bus.ex_is_load   = s.is_load;
        bus.ex_rd        = s.rd;
        bus.ex_redirect  = s.redirect;
        bus.ex_div_start = s.div_start;
        bus.div_done     = s.div_done;
        bus.mem_req      = s.mem_req;
        bus.mem_ack      = s.mem_ack;

        lu = s.ex_valid && s.is_load && (s.rd != 0) &&
             ((s.rs1_en && s.rs1 == s.rd) || (s.rs2_en && s.rs2 == s.rd));
        if (!s.rst)                        r = RReset;
        else if (m_mem)                    r = s.mem_ack ? RNone : RMem;
        else if (m_div)                    r = s.div_done ? RNone : RDivWait;
        else if (s.mem_req && !s.mem_ack)  r = RMem;
        else if (s.ex_valid && s.div_start) r = RDivStart;
        else if (s.ex_valid && s.redirect) r = RRedir;
        else if (lu)                       r = RLoadUse;
        else                               r = RNone;

        e.ctl = ctl_for(r);
        e.st  = m_mem ? 2'd1 : (m_div ? 2'd2 : 2'd0);
        e.cnt = m_cnt[CNT_W-1:0];
        exp_q.push_back(e);

        if (r == RReset) begin
            m_mem = 1'b0;
            m_div = 1'b0;
            m_cnt = 0;
        end else begin
            m_mem = (r == RMem);
            m_div = (r == RDivStart) || (r == RDivWait);
            if (e.ctl[8:5] != 4'b0 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
    endtask

    // Monitor: compares each cycle's outputs away from the active edge.
    initial begin
        exp_t       e;
        logic [8:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.hold_pc, bus.hold_ifid, bus.hold_idex, bus.hold_exmem,
                       bus.bubble_ifid, bus.bubble_idex, bus.bubble_exmem, bus.bubble_memwb,
                       bus.div_go};
                n_checks = n_checks + 3;
                if (got !== e.ctl) begin
                    n_fail = n_fail + 1;
                    $display("FAIL ctl t=%0t got=%b want=%b", $time, got, e.ctl);
                end
                if (bus.ctrl_state !== e.st) begin
                    n_fail = n_fail + 1;
                    $display("FAIL ctrl_state t=%0t got=%0d want=%0d", $time, bus.ctrl_state, e.st);
                end
                if (stall_cnt !== e.cnt) begin
                    n_fail = n_fail + 1;
                    $display("FAIL stall_cnt t=%0t got=%0d want=%0d", $time, stall_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cycles;
        // Unchecked initial reset so the state registers are known.
        rst = 1'b0;
        {bus.id_rs1, bus.id_rs2, bus.id_rs1_en, bus.id_rs2_en, bus.ex_valid, bus.ex_is_load,
         bus.ex_rd, bus.ex_redirect, bus.ex_div_start, bus.div_done, bus.mem_req,
         bus.mem_ack} = '0;
        repeat (2) @(posedge clk);

        // Reset held for 3 cycles, then idle.
        s = idle();
        s.rst = 1'b0;
        repeat (3) step(s);
        repeat (2) step(idle());

        // Load-use on rs2, then the same with rd = x0.
        s = idle();
        s.ex_valid = 1'b1; s.is_load = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.rs2_en = 1'b1;
        step(s);
        step(idle());
        s.rd = 5'd0; s.rs2 = 5'd0;
        step(s);
        step(idle());

        // Redirect wins over a simultaneous load-use.
        s = idle();
        s.ex_valid = 1'b1; s.is_load = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.rs1_en = 1'b1;
        s.redirect = 1'b1;
        step(s);
        step(idle());

        // Memory access acked after 3 wait cycles, then same-cycle ack.
        s = idle();
        s.mem_req = 1'b1;
        repeat (4) step(s);
        s.mem_ack = 1'b1;
        step(s);
        step(idle());
        step(s);
        step(idle());

        // Divide of 8 cycles.
        s = idle();
        s.ex_valid = 1'b1; s.div_start = 1'b1;
        step(s);
        s = idle();
        repeat (8) step(s);
        s.div_done = 1'b1;
        step(s);
        step(idle());

        // Divide start deferred behind a mem stall carrying a redirect too.
        s = idle();
        s.ex_valid = 1'b1; s.div_start = 1'b1; s.redirect = 1'b1; s.mem_req = 1'b1;
        repeat (3) step(s);
        s.mem_ack = 1'b1;
        step(s);
        s.mem_req = 1'b0; s.mem_ack = 1'b0;
        step(s);
        s = idle();
        repeat (2) step(s);
        s.div_done = 1'b1;
        step(s);

        // Continuous hold for 20 cycles drives the counter into saturation.
        s = idle();
        s.mem_req = 1'b1;
        repeat (20) step(s);
        s.mem_ack = 1'b1;
        step(s);
        step(idle());

        // Reset while waiting on the divider.
        s = idle();
        s.ex_valid = 1'b1; s.div_start = 1'b1;
        repeat (3) step(s);
        s.rst = 1'b0;
        step(s);
        repeat (2) step(idle());

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s           = idle();
            s.rst       = ($urandom_range(0, 59) != 0);
            s.rs1       = 5'($urandom_range(0, 3));
            s.rs2       = 5'($urandom_range(0, 3));
            s.rs1_en    = 1'($urandom_range(0, 1));
            s.rs2_en    = 1'($urandom_range(0, 1));
            s.ex_valid  = ($urandom_range(0, 4) != 0);
            s.is_load   = ($urandom_range(0, 2) == 0);
            s.rd        = 5'($urandom_range(0, 3));
            s.redirect  = ($urandom_range(0, 5) == 0);
            s.div_start = ($urandom_range(0, 7) == 0);
            s.div_done  = ($urandom_range(0, 4) == 0);
            s.mem_req   = ($urandom_range(0, 3) == 0);
            s.mem_ack   = ($urandom_range(0, 1) == 0);
            step(s);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        n_checks = n_checks + 1;
        if (exp_q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL drain got=%0d pending want=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
